// File: rtl/brg_cgra_xcel_link_balancer_pkg.sv
// brg_cgra_xcel_pkg: shared types and helpers for the CGRA accelerator link balancer.
// Holds the link-index width rule and the packed slave-request layout, which the
// balancer itself treats as an opaque bit vector.
package brg_cgra_xcel_pkg;

    // A single link still needs a 1-bit index so that pointer registers exist.
    function automatic int calc_link_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int default_num_links_lp = 4;
    localparam int link_idx_width_lp    = calc_link_idx_width(default_num_links_lp);
    localparam int stats_width_lp       = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        we;
        logic [3:0]  load_info;
        logic [5:0]  src_x;
        logic [5:0]  src_y;
    } slave_req_s;

endpackage

// File: rtl/brg_cgra_xcel_link_balancer_if.sv
// brg_cgra_xcel_link_balancer_if: groups the accelerator port pair and the per-link
// endpoint signals. The balancer uses the slave modport; the surrounding logic
// (accelerator + endpoints) uses the master modport.
import brg_cgra_xcel_pkg::*;

interface brg_cgra_xcel_link_balancer_if #(
    parameter int num_links_p       = 4,
    parameter int data_width_p      = 32,
    parameter int packet_width_p    = 64,
    parameter int slave_req_width_p = $bits(slave_req_s),
    parameter int max_out_credits_p = 32,
    parameter int reg_id_width_p    = 5
);
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1);

    logic                                            x_out_v_i;
    logic [packet_width_p-1:0]                       x_out_packet_i;
    logic                                            x_out_ready_o;
    logic [num_links_p-1:0]                          ep_out_v_o;
    logic [num_links_p-1:0][packet_width_p-1:0]      ep_out_packet_o;
    logic [num_links_p-1:0]                          ep_out_credit_or_ready_i;
    logic [num_links_p-1:0][credit_width_lp-1:0]     ep_out_credits_i;

    logic [num_links_p-1:0]                          ep_returned_v_i;
    logic [num_links_p-1:0][data_width_p-1:0]        ep_returned_data_i;
    logic [num_links_p-1:0][reg_id_width_p-1:0]      ep_returned_reg_id_i;
    logic [num_links_p-1:0]                          ep_returned_yumi_o;
    logic                                            x_returned_v_o;
    logic [data_width_p-1:0]                         x_returned_data_o;
    logic [reg_id_width_p-1:0]                       x_returned_reg_id_o;
    logic                                            x_returned_yumi_i;

    logic [num_links_p-1:0]                          ep_in_v_i;
    logic [num_links_p-1:0][slave_req_width_p-1:0]   ep_in_req_i;
    logic [num_links_p-1:0]                          ep_in_yumi_o;
    logic [num_links_p-1:0]                          ep_returning_v_o;
    logic [num_links_p-1:0][data_width_p-1:0]        ep_returning_data_o;
    logic                                            x_in_v_o;
    logic [slave_req_width_p-1:0]                    x_in_req_o;
    logic                                            x_in_yumi_i;
    logic                                            x_returning_v_i;
    logic [data_width_p-1:0]                         x_returning_data_i;

    logic                                            idle_o;

    modport slave (
        input  x_out_v_i, x_out_packet_i, ep_out_credit_or_ready_i, ep_out_credits_i,
        output x_out_ready_o, ep_out_v_o, ep_out_packet_o,
        input  ep_returned_v_i, ep_returned_data_i, ep_returned_reg_id_i, x_returned_yumi_i,
        output ep_returned_yumi_o, x_returned_v_o, x_returned_data_o, x_returned_reg_id_o,
        input  ep_in_v_i, ep_in_req_i, x_in_yumi_i, x_returning_v_i, x_returning_data_i,
        output ep_in_yumi_o, ep_returning_v_o, ep_returning_data_o, x_in_v_o, x_in_req_o,
        output idle_o
    );

    modport master (
        output x_out_v_i, x_out_packet_i, ep_out_credit_or_ready_i, ep_out_credits_i,
        input  x_out_ready_o, ep_out_v_o, ep_out_packet_o,
        output ep_returned_v_i, ep_returned_data_i, ep_returned_reg_id_i, x_returned_yumi_i,
        input  ep_returned_yumi_o, x_returned_v_o, x_returned_data_o, x_returned_reg_id_o,
        output ep_in_v_i, ep_in_req_i, x_in_yumi_i, x_returning_v_i, x_returning_data_i,
        input  ep_in_yumi_o, ep_returning_v_o, ep_returning_data_o, x_in_v_o, x_in_req_o,
        input  idle_o
    );

endinterface

// File: rtl/brg_cgra_xcel_link_balancer_rr_picker.sv
// brg_cgra_link_rr_picker: stateless round-robin search. Grants the first requesting
// link at or after the pointer. When hold is set and the pointer link is still
// requesting, the pointer link is granted outright (the caller parks the pointer on
// a presented-but-unaccepted grant so it stays stable).
import brg_cgra_xcel_pkg::*;

module brg_cgra_link_rr_picker #(
    parameter  int n_p      = 4,
    localparam int idx_w_lp = calc_link_idx_width(n_p)
) (
    input  logic [n_p-1:0]      req_i,
    input  logic [idx_w_lp-1:0] ptr_i,
    input  logic                hold_i,
    output logic [idx_w_lp-1:0] grant_o,
    output logic                any_o
);

    // Rotating priority search starting at the pointer.
    always_comb begin
        logic                found;
        logic [idx_w_lp-1:0] cand;
        found   = 1'b0;
        cand    = '0;
        grant_o = '0;
        any_o   = |req_i;
        for (int k = 0; k < n_p; k++) begin
            cand = idx_w_lp'((int'(ptr_i) + k) % n_p);
            if (!found && req_i[cand]) begin
                grant_o = cand;
                found   = 1'b1;
            end
        end
        if (hold_i && req_i[ptr_i]) begin
            grant_o = ptr_i;
        end
    end

endmodule

// File: rtl/brg_cgra_xcel_link_balancer.sv
// brg_cgra_xcel_link_balancer: spreads accelerator master requests over num_links_p
// endpoints with credit-aware round-robin, merges their responses back, and
// serialises incoming slave requests onto the single accelerator slave port.
// Optional per-link request counters: define BRG_CGRA_LINK_BALANCER_STATS_EN.
import brg_cgra_xcel_pkg::*;

module brg_cgra_xcel_link_balancer #(
    parameter int num_links_p       = 4,
    parameter int data_width_p      = 32,
    parameter int packet_width_p    = 64,
    parameter int slave_req_width_p = $bits(slave_req_s),
    parameter int max_out_credits_p = 32,
    parameter int reg_id_width_p    = 5
) (
    input  logic clk_i,
    input  logic reset_n_i,
    brg_cgra_xcel_link_balancer_if.slave link
`ifdef BRG_CGRA_LINK_BALANCER_STATS_EN
    ,
    output logic [num_links_p-1:0][stats_width_lp-1:0] stats_req_cnt_o
`endif
);

    localparam int idx_w_lp    = calc_link_idx_width(num_links_p);
    localparam int credit_w_lp = $clog2(max_out_credits_p + 1);
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_links_p - 1);

    logic [idx_w_lp-1:0]    mptr_r, rptr_r, sptr_r, sresp_idx_r;
    logic                   pending_r;
    logic [num_links_p-1:0] eligible;
    logic                   all_full;
    logic [idx_w_lp-1:0]    m_win, r_sel, s_sel;
    logic                   m_any, r_any, s_any;
    logic                   m_fire;

    function automatic logic [idx_w_lp-1:0] next_idx(input logic [idx_w_lp-1:0] i);
        return (i == last_idx_lp) ? '0 : i + idx_w_lp'(1);
    endfunction

    // A link can take a master request only if it is ready and has credits left.
    always_comb begin
        eligible = '0;
        all_full = 1'b1;
        for (int i = 0; i < num_links_p; i++) begin
            eligible[i] = link.ep_out_credit_or_ready_i[i] && (link.ep_out_credits_i[i] != '0);
            if (link.ep_out_credits_i[i] != credit_w_lp'(max_out_credits_p)) begin
                all_full = 1'b0;
            end
        end
    end

    brg_cgra_link_rr_picker #(.n_p(num_links_p)) master_picker (
        .req_i(eligible), .ptr_i(mptr_r), .hold_i(1'b0), .grant_o(m_win), .any_o(m_any)
    );

    brg_cgra_link_rr_picker #(.n_p(num_links_p)) resp_picker (
        .req_i(link.ep_returned_v_i), .ptr_i(rptr_r), .hold_i(~link.x_returned_yumi_i),
        .grant_o(r_sel), .any_o(r_any)
    );

    brg_cgra_link_rr_picker #(.n_p(num_links_p)) slave_picker (
        .req_i(link.ep_in_v_i), .ptr_i(sptr_r), .hold_i(~link.x_in_yumi_i),
        .grant_o(s_sel), .any_o(s_any)
    );

    assign m_fire = link.x_out_v_i && m_any;

    // Master side: steer valid to the winning link, broadcast the packet.
    always_comb begin
        link.x_out_ready_o = m_any;
        link.ep_out_v_o    = '0;
        if (m_any) begin
            link.ep_out_v_o[m_win] = link.x_out_v_i;
        end
        for (int i = 0; i < num_links_p; i++) begin
            link.ep_out_packet_o[i] = link.x_out_packet_i;
        end
    end

    // Response merge: the selected link drives the accelerator and receives its yumi.
    always_comb begin
        link.x_returned_v_o      = r_any;
        link.x_returned_data_o   = '0;
        link.x_returned_reg_id_o = '0;
        link.ep_returned_yumi_o  = '0;
        if (r_any) begin
            link.x_returned_data_o         = link.ep_returned_data_i[r_sel];
            link.x_returned_reg_id_o       = link.ep_returned_reg_id_i[r_sel];
            link.ep_returned_yumi_o[r_sel] = link.x_returned_yumi_i;
        end
    end

    // Slave path: forward the selected request, route the returning word back.
    always_comb begin
        link.x_in_v_o         = s_any;
        link.x_in_req_o       = '0;
        link.ep_in_yumi_o     = '0;
        link.ep_returning_v_o = '0;
        if (s_any) begin
            link.x_in_req_o          = link.ep_in_req_i[s_sel];
            link.ep_in_yumi_o[s_sel] = link.x_in_yumi_i;
        end
        link.ep_returning_v_o[sresp_idx_r] = link.x_returning_v_i && pending_r;
        for (int i = 0; i < num_links_p; i++) begin
            link.ep_returning_data_o[i] = link.x_returning_data_i;
        end
        link.idle_o = all_full && !pending_r;
    end

    // Pointer state; an unaccepted grant parks its pointer so the choice cannot shift.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mptr_r      <= '0;
            rptr_r      <= '0;
            sptr_r      <= '0;
            sresp_idx_r <= '0;
            pending_r   <= 1'b0;
        end else begin
            if (m_fire) begin
                mptr_r <= next_idx(m_win);
            end
            if (r_any) begin
                rptr_r <= link.x_returned_yumi_i ? next_idx(r_sel) : r_sel;
            end
            if (s_any) begin
                sptr_r <= link.x_in_yumi_i ? next_idx(s_sel) : s_sel;
                if (link.x_in_yumi_i) begin
                    sresp_idx_r <= s_sel;
                end
            end
            pending_r <= link.x_in_yumi_i;
        end
    end

`ifdef BRG_CGRA_LINK_BALANCER_STATS_EN
    logic [num_links_p-1:0][stats_width_lp-1:0] stats_cnt_r;

    // Count accepted master requests per link; counters wrap freely.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stats_cnt_r <= '0;
        end else begin
            for (int i = 0; i < num_links_p; i++) begin
                if (m_fire && (m_win == idx_w_lp'(i))) begin
                    stats_cnt_r[i] <= stats_cnt_r[i] + stats_width_lp'(1);
                end
            end
        end
    end

    assign stats_req_cnt_o = stats_cnt_r;
`endif

endmodule

// File: tb/tb_brg_cgra_xcel_link_balancer.sv
// tb_brg_cgra_xcel_link_balancer: self-checking bench with directed and randomized
// traffic checked against a round-robin reference model kept in plain integers.
import brg_cgra_xcel_pkg::*;

module tb_brg_cgra_xcel_link_balancer;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int PW = 64;
    localparam int SW = $bits(slave_req_s);
    localparam int MC = 32;
    localparam int RW = 5;
    localparam int CW = $clog2(MC + 1);

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    int m_ptr, r_ptr, s_ptr;

    always #5 clk = ~clk;

    brg_cgra_xcel_link_balancer_if #(
        .num_links_p(N), .data_width_p(DW), .packet_width_p(PW),
        .slave_req_width_p(SW), .max_out_credits_p(MC), .reg_id_width_p(RW)
    ) link ();

`ifdef BRG_CGRA_LINK_BALANCER_STATS_EN
    logic [N-1:0][31:0] stats_req_cnt;
`endif

    brg_cgra_xcel_link_balancer #(
        .num_links_p(N), .data_width_p(DW), .packet_width_p(PW),
        .slave_req_width_p(SW), .max_out_credits_p(MC), .reg_id_width_p(RW)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .link(link)
`ifdef BRG_CGRA_LINK_BALANCER_STATS_EN
        , .stats_req_cnt_o(stats_req_cnt)
`endif
    );

    // Reference: first requester at or after ptr, -1 if none.
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if ((req & (N'(1) << ((ptr + k) % N))) != '0) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return (i < 0) ? '0 : (N'(1) << i);
    endfunction

    task automatic clear_inputs();
        link.x_out_v_i = 1'b0;
        link.x_out_packet_i = '0;
        link.ep_out_credit_or_ready_i = '0;
        link.ep_out_credits_i = '0;
        link.ep_returned_v_i = '0;
        link.ep_returned_data_i = '0;
        link.ep_returned_reg_id_i = '0;
        link.x_returned_yumi_i = 1'b0;
        link.ep_in_v_i = '0;
        link.ep_in_req_i = '0;
        link.x_in_yumi_i = 1'b0;
        link.x_returning_v_i = 1'b0;
        link.x_returning_data_i = '0;
    endtask

    task automatic all_links_ready();
        link.ep_out_credit_or_ready_i = '1;
        for (int i = 0; i < N; i++) link.ep_out_credits_i[i] = CW'(MC);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        #1;
        tests_run++;
        if (link.x_out_ready_o !== 1'b0 || link.ep_out_v_o !== '0 || link.x_returned_v_o !== 1'b0 ||
            link.x_returned_data_o !== '0 || link.x_in_v_o !== 1'b0 || link.ep_returning_v_o !== '0 ||
            link.ep_in_yumi_o !== '0 || link.ep_returned_yumi_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got ready=%b ep_out_v=%b ret_v=%b in_v=%b returning=%b, expected all 0",
                     link.x_out_ready_o, link.ep_out_v_o, link.x_returned_v_o, link.x_in_v_o, link.ep_returning_v_o);
        end
        tests_run++;
        if (link.idle_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle_no_credit: got %b expected 0", link.idle_o);
        end
        all_links_ready();
        #1;
        tests_run++;
        if (link.idle_o !== 1'b1 || link.x_out_ready_o !== 1'b1 || link.ep_out_v_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_full_credit: got idle=%b ready=%b ep_out_v=%b expected 1 1 0000",
                     link.idle_o, link.x_out_ready_o, link.ep_out_v_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr = 0; r_ptr = 0; s_ptr = 0;
    endtask

    task automatic test_master_rr();
        logic [PW-1:0] pkt;
        all_links_ready();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pkt = {$urandom, $urandom};
            link.x_out_v_i = 1'b1;
            link.x_out_packet_i = pkt;
            #1;
            tests_run++;
            if (link.ep_out_v_o !== oh(c % N) || link.x_out_ready_o !== 1'b1 || link.ep_out_packet_o !== {N{pkt}}) begin
                tests_failed++;
                $display("[TB] FAIL master_rr[%0d]: got ep_out_v=%b ready=%b expected ep_out_v=%b ready=1",
                         c, link.ep_out_v_o, link.x_out_ready_o, oh(c % N));
            end
            m_ptr = (c % N + 1) % N;
        end
        @(negedge clk);
        link.x_out_v_i = 1'b0;
    endtask

    task automatic test_master_eligibility();
        logic [N-1:0] elig;
        int exp;
        bit full;
        link.ep_out_credits_i[1] = '0;
        link.ep_out_credit_or_ready_i[2] = 1'b0;
        for (int c = 0; c < 28; c++) begin
            if (c >= 4) begin
                full = 1'b1;
                for (int i = 0; i < N; i++) begin
                    link.ep_out_credit_or_ready_i[i] = ($urandom_range(0, 3) != 0);
                    link.ep_out_credits_i[i] = ($urandom_range(0, 2) == 0) ? CW'(MC) : CW'($urandom_range(0, MC));
                end
                link.x_out_v_i = $urandom_range(0, 3) != 0;
            end else begin
                link.x_out_v_i = 1'b1;
            end
            link.x_out_packet_i = {$urandom, $urandom};
            elig = '0;
            full = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (link.ep_out_credit_or_ready_i[i] && link.ep_out_credits_i[i] != 0) elig |= oh(i);
                if (link.ep_out_credits_i[i] != CW'(MC)) full = 1'b0;
            end
            exp = rr_pick(elig, m_ptr);
            #1;
            tests_run++;
            if (link.x_out_ready_o !== (exp >= 0) || link.ep_out_v_o !== (link.x_out_v_i ? oh(exp) : '0) ||
                link.idle_o !== full) begin
                tests_failed++;
                $display("[TB] FAIL master_elig[%0d]: got ready=%b ep_out_v=%b idle=%b expected ready=%b ep_out_v=%b idle=%b",
                         c, link.x_out_ready_o, link.ep_out_v_o, link.idle_o, exp >= 0,
                         link.x_out_v_i ? oh(exp) : '0, full);
            end
            if (link.x_out_v_i && exp >= 0) m_ptr = (exp + 1) % N;
            @(negedge clk);
        end
        link.x_out_v_i = 1'b0;
    endtask

    task automatic test_response_merge();
        logic [N-1:0] v;
        int held, exp;
        logic yumi;
        v = '1;
        held = -1;
        for (int i = 0; i < N; i++) begin
            link.ep_returned_data_i[i] = $urandom;
            link.ep_returned_reg_id_i[i] = RW'(5 + i);
        end
        for (int c = 0; c < 47; c++) begin
            @(negedge clk);
            if (c < 3) yumi = 1'b0;
            else if (c < 7) yumi = 1'b1;
            else begin
                for (int i = 0; i < N; i++) begin
                    if (!v[i] && $urandom_range(0, 2) == 0) begin
                        v[i] = 1'b1;
                        link.ep_returned_data_i[i] = $urandom;
                        link.ep_returned_reg_id_i[i] = RW'($urandom);
                    end
                end
                yumi = $urandom_range(0, 1);
            end
            link.ep_returned_v_i = v;
            link.x_returned_yumi_i = yumi;
            exp = (held >= 0) ? held : rr_pick(v, r_ptr);
            #1;
            tests_run++;
            if (link.x_returned_v_o !== (exp >= 0) ||
                link.ep_returned_yumi_o !== (yumi ? oh(exp) : '0) ||
                (exp >= 0 && (link.x_returned_data_o !== link.ep_returned_data_i[exp] ||
                              link.x_returned_reg_id_o !== link.ep_returned_reg_id_i[exp])) ||
                (exp < 0 && link.x_returned_data_o !== '0)) begin
                tests_failed++;
                $display("[TB] FAIL resp_merge[%0d]: got v=%b yumi=%b reg_id=%0d expected link %0d yumi=%b reg_id=%0d",
                         c, link.x_returned_v_o, link.ep_returned_yumi_o, link.x_returned_reg_id_o, exp,
                         yumi ? oh(exp) : '0, (exp >= 0) ? int'(link.ep_returned_reg_id_i[exp]) : 0);
            end
            if (c < 7 && exp != ((c < 3) ? 0 : c - 3)) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL resp_order[%0d]: model picked %0d", c, exp);
            end
            if (exp >= 0) begin
                if (yumi) begin
                    v[exp] = 1'b0;
                    r_ptr = (exp + 1) % N;
                    held = -1;
                end else begin
                    held = exp;
                end
            end
        end
        @(negedge clk);
        link.ep_returned_v_i = '0;
        link.x_returned_yumi_i = 1'b0;
    endtask

    task automatic test_slave_serialise();
        logic [SW-1:0] req2, req3;
        logic [DW-1:0] d2, d3;
        all_links_ready();
        req2 = SW'({$urandom, $urandom, $urandom});
        req3 = SW'({$urandom, $urandom, $urandom});
        d2 = $urandom; d3 = $urandom;
        link.ep_in_req_i[2] = req2;
        link.ep_in_req_i[3] = req3;
        link.ep_in_v_i = 4'b1100;
        link.x_in_yumi_i = 1'b1;
        #1;
        tests_run++;
        if (link.x_in_v_o !== 1'b1 || link.x_in_req_o !== req2 || link.ep_in_yumi_o !== 4'b0100 ||
            link.ep_returning_v_o !== '0 || link.idle_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL slave_t0: got in_v=%b yumi=%b returning=%b idle=%b expected 1 0100 0000 1",
                     link.x_in_v_o, link.ep_in_yumi_o, link.ep_returning_v_o, link.idle_o);
        end
        @(negedge clk);
        link.ep_in_v_i = 4'b1000;
        link.x_returning_v_i = 1'b1;
        link.x_returning_data_i = d2;
        #1;
        tests_run++;
        if (link.x_in_req_o !== req3 || link.ep_in_yumi_o !== 4'b1000 || link.ep_returning_v_o !== 4'b0100 ||
            link.ep_returning_data_o !== {N{d2}} || link.idle_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL slave_t1: got yumi=%b returning=%b idle=%b expected 1000 0100 0",
                     link.ep_in_yumi_o, link.ep_returning_v_o, link.idle_o);
        end
        @(negedge clk);
        link.ep_in_v_i = '0;
        link.x_in_yumi_i = 1'b0;
        link.x_returning_data_i = d3;
        #1;
        tests_run++;
        if (link.ep_returning_v_o !== 4'b1000 || link.ep_returning_data_o !== {N{d3}} ||
            link.x_in_v_o !== 1'b0 || link.idle_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL slave_t2: got returning=%b in_v=%b idle=%b expected 1000 0 0",
                     link.ep_returning_v_o, link.x_in_v_o, link.idle_o);
        end
        @(negedge clk);
        link.x_returning_v_i = 1'b0;
        #1;
        tests_run++;
        if (link.ep_returning_v_o !== '0 || link.idle_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL slave_t3: got returning=%b idle=%b expected 0000 1", link.ep_returning_v_o, link.idle_o);
        end
        s_ptr = 0;
    endtask

    task automatic test_slave_random();
        logic [N-1:0] sv;
        int held, exp, ret_link;
        logic yumi, ret_pend;
        sv = '0; held = -1; ret_pend = 1'b0; ret_link = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!sv[i] && $urandom_range(0, 2) == 0) begin
                    sv[i] = 1'b1;
                    link.ep_in_req_i[i] = SW'({$urandom, $urandom, $urandom});
                end
            end
            yumi = (sv != '0) && ($urandom_range(0, 1) == 1);
            link.ep_in_v_i = sv;
            link.x_in_yumi_i = yumi;
            link.x_returning_v_i = ret_pend;
            link.x_returning_data_i = $urandom;
            exp = (held >= 0) ? held : rr_pick(sv, s_ptr);
            #1;
            tests_run++;
            if (link.x_in_v_o !== (exp >= 0) || link.ep_in_yumi_o !== (yumi ? oh(exp) : '0) ||
                (exp >= 0 && link.x_in_req_o !== link.ep_in_req_i[exp]) ||
                link.ep_returning_v_o !== (ret_pend ? oh(ret_link) : '0) || link.idle_o !== !ret_pend) begin
                tests_failed++;
                $display("[TB] FAIL slave_rand[%0d]: got in_v=%b yumi=%b returning=%b idle=%b expected link %0d yumi=%b returning=%b idle=%b",
                         c, link.x_in_v_o, link.ep_in_yumi_o, link.ep_returning_v_o, link.idle_o, exp,
                         yumi ? oh(exp) : '0, ret_pend ? oh(ret_link) : '0, !ret_pend);
            end
            ret_pend = yumi;
            if (exp >= 0) begin
                if (yumi) begin
                    ret_link = exp;
                    sv[exp] = 1'b0;
                    s_ptr = (exp + 1) % N;
                    held = -1;
                end else begin
                    held = exp;
                end
            end
        end
        @(negedge clk);
        link.ep_in_v_i = '0;
        link.x_in_yumi_i = 1'b0;
        link.x_returning_v_i = ret_pend;
        #1;
        tests_run++;
        if (link.ep_returning_v_o !== (ret_pend ? oh(ret_link) : '0)) begin
            tests_failed++;
            $display("[TB] FAIL slave_drain: got %b expected %b", link.ep_returning_v_o, ret_pend ? oh(ret_link) : '0);
        end
        @(negedge clk);
        link.x_returning_v_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        link.ep_out_credit_or_ready_i = 4'b0010;
        link.x_out_v_i = 1'b1;
        link.ep_returned_v_i = 4'b0010;
        link.x_returned_yumi_i = 1'b1;
        link.ep_in_v_i = 4'b0010;
        link.x_in_yumi_i = 1'b1;
        #1;
        tests_run++;
        if (link.ep_out_v_o !== 4'b0010 || link.ep_returned_yumi_o !== 4'b0010 || link.ep_in_yumi_o !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL mid_setup: got ep_out_v=%b ret_yumi=%b in_yumi=%b expected 0010 each",
                     link.ep_out_v_o, link.ep_returned_yumi_o, link.ep_in_yumi_o);
        end
        @(negedge clk);
        clear_inputs();
        link.x_returning_v_i = 1'b1;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (link.ep_returning_v_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_drop: got %b expected 0000", link.ep_returning_v_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (link.ep_returning_v_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_after_reset: got %b expected 0000", link.ep_returning_v_o);
        end
        @(negedge clk);
        link.x_returning_v_i = 1'b0;
        all_links_ready();
        link.x_out_v_i = 1'b1;
        link.ep_returned_v_i = '1;
        link.ep_in_v_i = '1;
        for (int i = 0; i < N; i++) begin
            link.ep_returned_data_i[i] = DW'(32'h100 + i);
            link.ep_in_req_i[i] = SW'(32'h200 + i);
        end
        #1;
        tests_run++;
        if (link.ep_out_v_o !== 4'b0001 || link.x_returned_data_o !== DW'(32'h100) || link.x_in_req_o !== SW'(32'h200)) begin
            tests_failed++;
            $display("[TB] FAIL mid_ptrs_zero: got ep_out_v=%b ret_data=%h in_req=%h expected 0001 100 200",
                     link.ep_out_v_o, link.x_returned_data_o, link.x_in_req_o);
        end
        @(negedge clk);
        clear_inputs();
        all_links_ready();
    endtask

`ifdef BRG_CGRA_LINK_BALANCER_STATS_EN
    task automatic test_stats();
        int cnt[N];
        int exp;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        all_links_ready();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            link.x_out_v_i = 1'b1;
            exp = rr_pick('1, m_ptr);
            cnt[exp]++;
            m_ptr = (exp + 1) % N;
        end
        @(negedge clk);
        link.x_out_v_i = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (stats_req_cnt[i] !== 32'(cnt[i])) begin
                tests_failed++;
                $display("[TB] FAIL stats_cnt[%0d]: got %0d expected %0d", i, stats_req_cnt[i], cnt[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_master_rr();
        test_master_eligibility();
        test_response_merge();
        test_slave_serialise();
        test_slave_random();
        test_reset_mid();
`ifdef BRG_CGRA_LINK_BALANCER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/brg_cgra_xcel_link_balancer.md
# brg_cgra_xcel_link_balancer

Sits between a CGRA accelerator's single HB endpoint-style port pair and `num_links_p` `bsg_manycore_endpoint_standard` instances. It removes the single-memory-master restriction by spreading outgoing master requests across all links with credit-aware round-robin. It merges returned responses from all links back to the accelerator, and serialises incoming slave requests from every link onto the accelerator's one slave port, steering each `returning` word back to the link it came from.

## Interface
- `num_links_p`, 4: number of mesh links / endpoints, 1..8.
- `data_width_p`, 32: data word width.
- `packet_width_p`, "inv": master packet width; the packet is opaque to this block.
- `slave_req_width_p`, "inv": packed width of {addr, data, mask, we, load_info, src_x, src_y}; opaque.
- `max_out_credits_p`, 32: endpoint credit count.
- `reg_id_width_p`, 5: returned register-id width.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `x_out_v_i` in 1, `x_out_packet_i` in `packet_width_p`, `x_out_ready_o` out 1: accelerator master request.
- `ep_out_v_o` out N, `ep_out_packet_o` out N×`packet_width_p`, `ep_out_credit_or_ready_i` in N, `ep_out_credits_i` in N×clog2(`max_out_credits_p`+1): endpoint master side.
- `ep_returned_v_i` in N, `ep_returned_data_i` in N×`data_width_p`, `ep_returned_reg_id_i` in N×`reg_id_width_p`, `ep_returned_yumi_o` out N: endpoint responses.
- `x_returned_v_o`, `x_returned_data_o`, `x_returned_reg_id_o` out; `x_returned_yumi_i` in: merged response stream.
- `ep_in_v_i` in N, `ep_in_req_i` in N×`slave_req_width_p`, `ep_in_yumi_o` out N: endpoint slave requests.
- `ep_returning_v_o` out N, `ep_returning_data_o` out N×`data_width_p`: slave responses to endpoints.
- `x_in_v_o` out 1, `x_in_req_o` out `slave_req_width_p`, `x_in_yumi_i` in 1, `x_returning_v_i` in 1, `x_returning_data_i` in `data_width_p`: accelerator slave port.
- `idle_o` out 1: every link holds full credits and no slave response is pending.

## Operation
- Master dispatch: link i is eligible when `ep_out_credit_or_ready_i[i]`=1 and `ep_out_credits_i[i]`!=0. `x_out_ready_o` = OR of eligible links. The winner is the first eligible link at or after `mptr_r`. `ep_out_v_o[i]` = `x_out_v_i` & win==i. The packet is broadcast to all links. On a handshake, `mptr_r` ← (win+1) mod N.
- Response merge: round-robin over `ep_returned_v_i` starting at `rptr_r`. Selected link drives the `x_returned_*` outputs. `ep_returned_yumi_o[sel]` = `x_returned_yumi_i`. On yumi, `rptr_r` ← sel+1 mod N. The selection is held stable while `x_returned_v_o`=1 and no yumi occurs; `rptr_r` does not move.
- Slave serialisation: round-robin over `ep_in_v_i` starting at `sptr_r`, with the same hold rule. `x_in_v_o`/`x_in_req_o` come from the selected link. `ep_in_yumi_o[sel]` = `x_in_yumi_i`. On yumi, `sptr_r` ← sel+1 and `sresp_idx_r` ← sel.
- Slave return: `ep_returning_v_o[sresp_idx_r]` = `x_returning_v_i`. Data is broadcast.
- `idle_o`=1 when all `ep_out_credits_i`==`max_out_credits_p` and `x_in_yumi_i` was not asserted last cycle.

## Timing
- All forward paths are combinational, with 0-cycle added latency. The only state is the pointers, `sresp_idx_r`, a 1-bit pending flag and the stats counters.
- Reset (`reset_n_i`=0, async): all pointers 0, `sresp_idx_r` 0, pending flag 0, stats 0. All outputs are then combinational functions of inputs. With no valid input, all outputs are 0.
- Returning is exactly 1 cycle after `x_in_yumi_i`. Back-to-back yumis are allowed; `sresp_idx_r` is rewritten every cycle.
- Reset mid-operation drops a pending returning. Endpoints are reset in the same domain.
- N=1: the pointers are constant 0 and the block is pass-through.
- Wrap-around: a pointer at N−1 advances to 0.

## Configuration
- `BRG_CGRA_LINK_BALANCER_STATS_EN` defined: adds a 32-bit wrapping counter per link, incremented on each master handshake on that link. Adds output port `stats_req_cnt_o` (N×32).
- Undefined: no counters and no port.

## Structure
- `brg_cgra_xcel_pkg` holds `link_idx_width_lp` = max(1, clog2(`num_links_p`)) and the slave-request packed struct.
- One sub-module, `brg_cgra_link_rr_picker`, is instantiated three times. Parameter `n_p`. Inputs: request vector, pointer, hold. Outputs: grant index, any.

## Test plan
- N=4, all links eligible, 8 back-to-back master requests -> links 0,1,2,3,0,1,2,3; `x_out_ready_o` held at 1.
- Link 1 credits=0, link 2 `credit_or_ready`=0, 4 requests -> links 0,3,0,3.
- All links return simultaneously with reg_ids 5,6,7,8; yumi each cycle -> delivered in order link 0,1,2,3. With yumi withheld 3 cycles, link 0 data is held stable.
- Slave requests on links 2 and 3 together; yumi cycles t and t+1 -> returning appears on link 2 at t+1 and link 3 at t+2.
- Reset asserted during pending returning -> no `ep_returning_v_o`. Pointers are 0 and next request goes to link 0.
- STATS_EN: 10 requests with all links eligible -> counts 3,3,2,2.
